// File: rtl/evg_evr_pkg.sv
// Shared event-link definitions for the event generator (tx) and receiver (rx) sides.
package evg_evr_pkg;

  localparam logic [7:0] CODE_NULL     = 8'h00;
  localparam logic [7:0] CODE_TOD_ZERO = 8'h70;
  localparam logic [7:0] CODE_TOD_ONE  = 8'h71;
  localparam logic [7:0] CODE_SECONDS  = 8'h7D;
  localparam logic [7:0] K28_5         = 8'hBC;

  typedef enum logic [1:0] {
    TOD_IDLE = 2'd0,
    TOD_GAP  = 2'd1,
    TOD_BIT  = 2'd2
  } tod_state_t;

  // Codes the link reserves for itself; users may not inject them.
  function automatic logic is_reserved_code(input logic [7:0] code);
    return (code == CODE_NULL) || (code == CODE_TOD_ZERO) ||
           (code == CODE_TOD_ONE) || (code == CODE_SECONDS);
  endfunction

endpackage

// File: rtl/tod_transmitter.sv
// Serialises the next-second value MSB first, one bit per free slot, spaced by a gap counter.
module tod_transmitter
  import evg_evr_pkg::*;
#(
  parameter int unsigned TOD_BIT_SPACING = 16,
  parameter int unsigned SECONDS_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     restart,
  input  logic [SECONDS_WIDTH-1:0] restart_value,
  input  logic                     bit_taken,
  output logic                     bit_pending,
  output logic                     bit_value,
  output logic                     active
);

  localparam int unsigned CNT_W = $clog2(SECONDS_WIDTH + 1);
  localparam logic [7:0] GAP_LAST = 8'(TOD_BIT_SPACING - 2);
  localparam logic [CNT_W-1:0] BITS_ALL = CNT_W'(SECONDS_WIDTH);

  tod_state_t               state;
  logic [SECONDS_WIDTH-1:0] shift_reg;
  logic [7:0]               gap_cnt;
  logic [CNT_W-1:0]         bits_left;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TOD_IDLE;
      shift_reg <= '0;
      gap_cnt   <= '0;
      bits_left <= '0;
    end else if (restart) begin
      state     <= TOD_GAP;
      shift_reg <= restart_value;
      gap_cnt   <= '0;
      bits_left <= BITS_ALL;
    end else begin
      case (state)
        TOD_GAP: begin
          if (gap_cnt == GAP_LAST) state <= TOD_BIT;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        TOD_BIT: begin
          if (bit_taken) begin
            shift_reg <= {shift_reg[SECONDS_WIDTH-2:0], 1'b0};
            bits_left <= bits_left - CNT_W'(1);
            gap_cnt   <= '0;
            state     <= (bits_left == CNT_W'(1)) ? TOD_IDLE : TOD_GAP;
          end
        end
        default: state <= TOD_IDLE;
      endcase
    end
  end

  assign bit_pending = (state == TOD_BIT);
  assign bit_value   = shift_reg[SECONDS_WIDTH-1];
  assign active      = (state != TOD_IDLE);

endmodule

// File: rtl/tiny_evg_tx.sv
// Event generator transmit slot arbiter: seconds marker > user event > TOD bit > K28.5 idle.
module tiny_evg_tx
  import evg_evr_pkg::*;
#(
  parameter int unsigned TOD_BIT_SPACING      = 16,
  parameter int unsigned SECONDS_WIDTH        = 32,
  parameter int unsigned STATUS_COUNTER_WIDTH = 10
) (
  input  logic                            evgTxClk,
  input  logic                            rst,
  input  logic                            ppsIn,
  input  logic                            secondsLoad,
  input  logic [SECONDS_WIDTH-1:0]        secondsValue,
  input  logic                            evValid,
  input  logic [7:0]                      evCode,
  output logic                            evReady,
  input  logic [7:0]                      distributedDataBus,
  output logic [15:0]                     evgTxWord,
  output logic [1:0]                      evgTxCharIsK,
  output logic [SECONDS_WIDTH-1:0]        seconds,
  output logic                            todShiftActive,
  output logic [STATUS_COUNTER_WIDTH-1:0] tooFewBitsCounter,
  output logic [STATUS_COUNTER_WIDTH-1:0] rejectedCodeCounter
);

  logic                     bit_pending;
  logic                     bit_value;
  logic                     bit_taken;
  logic                     tod_active;
  logic                     restart;
  logic [SECONDS_WIDTH-1:0] restart_value;
  logic                     user_send;
  logic                     user_drop;
  logic [7:0]               slot_code;
  logic                     slot_k;

  assign evReady = !ppsIn && !rst;

  always_comb begin
    user_send     = evValid && evReady && !is_reserved_code(evCode);
    user_drop     = evValid && evReady && is_reserved_code(evCode);
    bit_taken     = bit_pending && !ppsIn && !user_send;
    slot_code     = K28_5;
    slot_k        = 1'b1;
    if (ppsIn) begin
      slot_code = CODE_SECONDS;
      slot_k    = 1'b0;
    end else if (user_send) begin
      slot_code = evCode;
      slot_k    = 1'b0;
    end else if (bit_pending) begin
      slot_code = bit_value ? CODE_TOD_ONE : CODE_TOD_ZERO;
      slot_k    = 1'b0;
    end
    // The shifted value always announces the second that the next marker opens.
    restart       = ppsIn || secondsLoad;
    restart_value = secondsLoad ? (secondsValue + SECONDS_WIDTH'(1))
                                : (seconds + SECONDS_WIDTH'(2));
  end

  tod_transmitter #(
    .TOD_BIT_SPACING(TOD_BIT_SPACING),
    .SECONDS_WIDTH  (SECONDS_WIDTH)
  ) u_tod (
    .clk          (evgTxClk),
    .rst          (rst),
    .restart      (restart),
    .restart_value(restart_value),
    .bit_taken    (bit_taken),
    .bit_pending  (bit_pending),
    .bit_value    (bit_value),
    .active       (tod_active)
  );

  assign todShiftActive = tod_active;

  always_ff @(posedge evgTxClk or posedge rst) begin
    if (rst) begin
      evgTxWord           <= {8'h00, K28_5};
      evgTxCharIsK        <= 2'b01;
      seconds             <= '0;
      tooFewBitsCounter   <= '0;
      rejectedCodeCounter <= '0;
    end else begin
      evgTxWord    <= {distributedDataBus, slot_code};
      evgTxCharIsK <= {1'b0, slot_k};
      if (secondsLoad) seconds <= secondsValue;
      else if (ppsIn) seconds <= seconds + SECONDS_WIDTH'(1);
      if (ppsIn && tod_active && (tooFewBitsCounter != '1))
        tooFewBitsCounter <= tooFewBitsCounter + STATUS_COUNTER_WIDTH'(1);
      if (user_drop && (rejectedCodeCounter != '1))
        rejectedCodeCounter <= rejectedCodeCounter + STATUS_COUNTER_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_tiny_evg_tx.sv
// Self-checking bench for tiny_evg_tx: timestamp-based slot model plus directed scenarios and random traffic.
module tb_tiny_evg_tx;

  localparam int unsigned W  = 32;
  localparam int unsigned SP = 16;
  localparam int unsigned CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ppsIn = 1'b0;
  logic          secondsLoad = 1'b0;
  logic [W-1:0]  secondsValue = '0;
  logic          evValid = 1'b0;
  logic [7:0]    evCode = '0;
  logic [7:0]    bus = '0;
  logic          evReady;
  logic [15:0]   word;
  logic [1:0]    isk;
  logic [W-1:0]  seconds;
  logic          active;
  logic [CW-1:0] toofew;
  logic [CW-1:0] rej;

  tiny_evg_tx #(
    .TOD_BIT_SPACING     (SP),
    .SECONDS_WIDTH       (W),
    .STATUS_COUNTER_WIDTH(CW)
  ) dut (
    .evgTxClk           (clk),
    .rst                (rst),
    .ppsIn              (ppsIn),
    .secondsLoad        (secondsLoad),
    .secondsValue       (secondsValue),
    .evValid            (evValid),
    .evCode             (evCode),
    .evReady            (evReady),
    .distributedDataBus (bus),
    .evgTxWord          (word),
    .evgTxCharIsK       (isk),
    .seconds            (seconds),
    .todShiftActive     (active),
    .tooFewBitsCounter  (toofew),
    .rejectedCodeCounter(rej)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit checking = 1'b0;

  // Model: expected outputs plus the shift described as value / bits sent / earliest next-bit cycle.
  logic [15:0]   e_word;
  logic [1:0]    e_isk;
  logic [W-1:0]  e_sec;
  logic [CW-1:0] e_toofew;
  logic [CW-1:0] e_rej;
  bit            m_active;
  logic [W-1:0]  m_val;
  int unsigned   m_sent;
  int unsigned   m_next_ok;
  int unsigned   cyc = 0;

  bit          bitq[$];
  int unsigned cycq[$];
  int unsigned ncyc = 0;
  logic [7:0]  rsv_codes [4] = '{8'h00, 8'h70, 8'h71, 8'h7D};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    e_word = 16'h00BC; e_isk = 2'b01; e_sec = '0; e_toofew = '0; e_rej = '0;
    m_active = 1'b0; m_val = '0; m_sent = 0; m_next_ok = 0;
  endtask

  task automatic model_step();
    bit acc, rsv, send, due, k;
    logic [7:0] code;
    acc  = evValid && !ppsIn;
    rsv  = (evCode == 8'h00) || (evCode == 8'h70) || (evCode == 8'h71) || (evCode == 8'h7D);
    send = acc && !rsv;
    due  = m_active && (cyc >= m_next_ok);
    if (ppsIn && m_active && (e_toofew != '1)) e_toofew = e_toofew + 1'b1;
    if (acc && rsv && (e_rej != '1)) e_rej = e_rej + 1'b1;
    code = 8'hBC; k = 1'b1;
    if (ppsIn) begin
      code = 8'h7D; k = 1'b0;
    end else if (send) begin
      code = evCode; k = 1'b0;
    end else if (due) begin
      code = m_val[W-1-m_sent] ? 8'h71 : 8'h70;
      k = 1'b0;
      m_sent++;
      m_next_ok = cyc + SP;
      if (m_sent == W) m_active = 1'b0;
    end
    e_word = {bus, code};
    e_isk  = {1'b0, k};
    if (secondsLoad) begin
      e_sec = secondsValue; m_val = secondsValue + 1;
    end else if (ppsIn) begin
      e_sec = e_sec + 1; m_val = e_sec + 1;
    end
    if (secondsLoad || ppsIn) begin
      m_active = 1'b1; m_sent = 0; m_next_ok = cyc + SP;
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("word", word, e_word);
      check("charisk", isk, e_isk);
      check("seconds", seconds, e_sec);
      check("shift_active", active, m_active);
      check("too_few", toofew, e_toofew);
      check("rejected", rej, e_rej);
      check("ev_ready", evReady, !ppsIn && !rst);
      ncyc++;
      if (!rst && isk == 2'b00 && (word[7:0] == 8'h70 || word[7:0] == 8'h71)) begin
        bitq.push_back(word[0]);
        cycq.push_back(ncyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus = 8'($urandom);
  endtask

  task automatic clear_log();
    bitq.delete();
    cycq.delete();
  endtask

  task automatic wait_bits(input int unsigned n, input string name);
    int unsigned k = 0;
    while (bitq.size() < int'(n) && k < W * SP + 200) begin
      tick();
      k++;
    end
    check(name, 64'(bitq.size() >= int'(n)), 64'd1);
  endtask

  function automatic logic [W-1:0] assemble();
    logic [W-1:0] v = '0;
    for (int i = 0; i < int'(W); i++) v = {v[W-2:0], bitq[i]};
    return v;
  endfunction

  function automatic int unsigned min_gap();
    int unsigned g = 32'hFFFF_FFFF;
    for (int i = 1; i < bitq.size(); i++)
      if (cycq[i] - cycq[i-1] < g) g = cycq[i] - cycq[i-1];
    return g;
  endfunction

  task automatic pulse_pps();
    ppsIn = 1'b1; tick(); ppsIn = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    checking = 1'b1;
    #1;
    check("reset_word", word, 16'h00BC);
    check("reset_charisk", isk, 2'b01);
    check("reset_active", active, 1'b0);
    check("reset_seconds", seconds, 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // pps mid-shift restarts from the MSB and counts an incomplete shift
    pulse_pps();
    clear_log();
    wait_bits(10, "wait_ten_bits");
    pulse_pps();
    clear_log();
    @(negedge clk);
    check("marker_midshift", word[7:0], 8'h7D);
    check("too_few_one", toofew, 10'd1);
    wait_bits(W, "wait_restart_shift");
    check("restart_value", assemble(), 32'h0000_0003);

    // load then pps: marker, new second, announced value, spacing
    secondsLoad = 1'b1; secondsValue = 32'h1234_5677; tick(); secondsLoad = 1'b0;
    pulse_pps();
    clear_log();
    @(negedge clk);
    check("marker_word", word[7:0], 8'h7D);
    check("marker_charisk", isk, 2'b00);
    check("seconds_after_pps", seconds, 32'h1234_5678);
    wait_bits(W, "wait_shift_load");
    check("tod_value_load", assemble(), 32'h1234_5679);
    check("tod_gap_load", 64'(min_gap() >= SP), 64'd1);

    // user event holds off a pending TOD bit without losing it
    pulse_pps();
    clear_log();
    evValid = 1'b1; evCode = 8'h2A;
    repeat (30) tick();
    evValid = 1'b0;
    check("no_bit_under_user", 64'(bitq.size()), 64'd0);
    wait_bits(W, "wait_shift_user");
    check("tod_value_user", assemble(), 32'h1234_567A);

    // pps and user request in the same cycle
    clear_log();
    ppsIn = 1'b1; evValid = 1'b1; evCode = 8'h55;
    #1 check("ready_low_on_pps", evReady, 1'b0);
    tick();
    ppsIn = 1'b0;
    #1 check("ready_after_pps", evReady, 1'b1);
    @(negedge clk);
    check("marker_before_user", word[7:0], 8'h7D);
    tick();
    evValid = 1'b0;
    @(negedge clk);
    check("user_after_marker", word[7:0], 8'h55);
    check("seconds_after_second_pps", seconds, 32'h1234_567A);
    wait_bits(W, "wait_shift_same_cycle");
    check("tod_value_same_cycle", assemble(), 32'h1234_567B);

    // reserved user code dropped; seconds wrap
    evValid = 1'b1; evCode = 8'h71; tick(); evValid = 1'b0;
    @(negedge clk);
    check("reserved_not_sent", word[7:0], 8'hBC);
    check("rejected_one", rej, 10'd1);
    secondsLoad = 1'b1; secondsValue = 32'hFFFF_FFFF; tick(); secondsLoad = 1'b0;
    pulse_pps();
    @(negedge clk);
    check("seconds_wrap", seconds, 32'h0);

    // reset mid-shift aborts and keeps the link quiet until the next pps
    clear_log();
    wait_bits(5, "wait_before_reset");
    rst = 1'b1;
    #1;
    check("midreset_word", word, 16'h00BC);
    check("midreset_charisk", isk, 2'b01);
    check("midreset_active", active, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    clear_log();
    for (int i = 0; i < 600; i++) begin
      evValid = ($urandom_range(0, 2) == 0);
      evCode  = ($urandom_range(0, 1) == 0) ? rsv_codes[$urandom_range(0, 3)] : 8'($urandom);
      tick();
    end
    evValid = 1'b0;
    check("no_tod_after_reset", 64'(bitq.size()), 64'd0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      ppsIn        = ($urandom_range(0, 299) == 0);
      secondsLoad  = ($urandom_range(0, 999) == 0);
      secondsValue = $urandom;
      evValid      = ($urandom_range(0, 2) == 0);
      evCode       = ($urandom_range(0, 3) == 0) ? rsv_codes[$urandom_range(0, 3)] : 8'($urandom);
      tick();
    end
    ppsIn = 1'b0; secondsLoad = 1'b0; evValid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tiny_evg_tx.md
TINY_EVG_TX -- requirements
Module: tiny_evg_tx

Interface
REQ-001 SHALL have parameter TOD_BIT_SPACING, default 16, minimum cycles between successive time-of-day shift bits (legal range 2..255).
REQ-002 SHALL have parameter SECONDS_WIDTH, default 32, width of the seconds count.
REQ-003 SHALL have parameter STATUS_COUNTER_WIDTH, default 10, width of the status counters.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: port `evgTxClk` (input, 1) is the single clock; port `rst` (input, 1) is the reset.
REQ-005 SHALL have port `ppsIn`, input, 1: single-cycle pulse-per-second strobe, synchronous to `evgTxClk`.
REQ-006 SHALL have port `secondsLoad`, input, 1: strobe that loads `secondsValue`.
REQ-007 SHALL have port `secondsValue`, input, SECONDS_WIDTH: current-second value to load.
REQ-008 SHALL have port `evValid`, input, 1: user event request.
REQ-009 SHALL have port `evCode`, input, 8: user event code.
REQ-010 SHALL have port `evReady`, output, 1: user event accepted this cycle when high together with `evValid`.
REQ-011 SHALL have port `distributedDataBus`, input, 8: transmitted in the high byte.
REQ-012 SHALL have port `evgTxWord`, output, 16: transceiver data; [7:0] is the event code, [15:8] is the distributed bus.
REQ-013 SHALL have port `evgTxCharIsK`, output, 2: per-byte K-character flags.
REQ-014 SHALL have port `seconds`, output, SECONDS_WIDTH: the current second.
REQ-015 SHALL have port `todShiftActive`, output, 1: high while shift bits remain to be sent.
REQ-016 SHALL have port `tooFewBitsCounter`, output, STATUS_COUNTER_WIDTH: counts markers sent with an incomplete shift.
REQ-017 SHALL have port `rejectedCodeCounter`, output, STATUS_COUNTER_WIDTH: counts user codes 0x00, 0x70, 0x71 or 0x7D that were dropped.

Function
REQ-018 SHALL register all outputs except `evReady`; a slot decided in cycle N appears on `evgTxWord` in cycle N+1.
REQ-019 SHALL fill each slot by fixed priority: seconds marker 0x7D (when `ppsIn` is high), then an accepted user event, then a pending TOD bit, then idle.
REQ-020 SHALL drive `evReady` combinationally as !`ppsIn` and !`rst`.
REQ-021 SHALL transmit a valid accepted user code verbatim with `evgTxCharIsK`=2'b00.
REQ-022 SHALL consume user codes 0x00/0x70/0x71/0x7D on handshake without transmitting them, increment `rejectedCodeCounter`, and leave the slot available to lower priorities.
REQ-023 SHALL send the TOD shift bit as code 0x70 for a 0 bit and 0x71 for a 1 bit, MSB first, SECONDS_WIDTH bits, shifting the value `seconds`+1.
REQ-024 SHALL implement a TOD state machine with states TOD_IDLE, TOD_GAP and TOD_BIT:
- TOD_GAP counts TOD_BIT_SPACING-1 cycles, then goes to TOD_BIT.
- TOD_BIT waits for a free slot, emits the bit, then goes to TOD_GAP; after the last bit it goes to TOD_IDLE.
REQ-025 SHALL, on `ppsIn`, emit 0x7D, set `seconds` to `seconds`+1 (wrapping at 2^SECONDS_WIDTH), and restart the shift in TOD_GAP with the new `seconds`+1.
REQ-026 SHALL, if `ppsIn` arrives while the state is not TOD_IDLE, still send the marker, increment `tooFewBitsCounter`, and restart the shift.
REQ-027 SHALL, on `secondsLoad`, set `seconds` to `secondsValue` and restart the shift with `secondsValue`+1; if `ppsIn` arrives in the same cycle, the load wins for the value and the marker is still sent.
REQ-028 SHALL send an idle slot as `evgTxWord`[7:0]=0xBC (K28.5) with `evgTxCharIsK`=2'b01.
REQ-029 SHALL set `evgTxWord`[15:8] to `distributedDataBus` registered, with `evgTxCharIsK`[1]=0 always.
REQ-030 SHALL saturate both status counters at all-ones.
REQ-031 SHALL drive `todShiftActive` high exactly when the state is not TOD_IDLE.

Reset
REQ-032 SHALL, while `rst` is high, asynchronously force:
- `evgTxWord`=16'h00BC and `evgTxCharIsK`=2'b01;
- `seconds`=0 and both counters=0;
- the TOD state to TOD_IDLE and `todShiftActive`=0.
REQ-033 SHALL abort any shift in progress when reset is asserted, and SHALL emit no TOD bits after reset until the first `ppsIn` or `secondsLoad`.

Structure
REQ-034 SHALL place the event code constants (0x70, 0x71, 0x7D), the K28.5 value 0xBC and the TOD state encoding in shared package `evg_evr_pkg`, for use by the receiver side.
REQ-035 SHALL implement the TOD shift register, gap counter and state machine in sub-module `tod_transmitter`, which exposes bit-pending, bit-value and bit-taken signals.

Verification
REQ-036 SHALL cover: `secondsLoad` with `secondsValue`=0x12345677, then `ppsIn` -> word 0x007D, `seconds`=0x12345678, then 32 bits encoding 0x12345679, each gap >=16 cycles.
REQ-037 SHALL cover: `evValid` held with `evCode`=0x2A during a pending TOD bit -> 0x2A sent first, TOD bit delayed and not lost, full value intact.
REQ-038 SHALL cover: `ppsIn` and `evValid` in the same cycle -> `evReady`=0, 0x7D sent, user event sent the next cycle.
REQ-039 SHALL cover: `ppsIn` after 10 bits shifted -> 0x7D sent, `tooFewBitsCounter`=1, shift restarts from the MSB.
REQ-040 SHALL cover: `evCode`=0x71 accepted -> not transmitted, `rejectedCodeCounter`=1; with `seconds`=0xFFFFFFFF and `ppsIn` -> `seconds`=0.
REQ-041 SHALL cover: `rst` asserted mid-shift -> `evgTxWord`=0x00BC, `evgTxCharIsK`=01, `todShiftActive`=0, no 0x70/0x71 codes until the next `ppsIn`.
